fcvt_seq: RTL and testbench
===========================

Name: fcvt_seq

Overview:
- Multi-cycle IEEE754 single-precision ⇄ 32-bit integer converter for the FP execute stage, sitting beside the combinational FP add/sub unit.
- Int→float direction (FCVT.S.W/WU) packs an integer into IEEE754 format.
- Float→int direction (FCVT.W.S/WU) unpacks an IEEE754 value to an integer.
- Normalization and denormalization shift one bit per cycle under a state machine, using a start/busy/done handshake.

Parameters:
- SAT_NEG_UNSIGNED, 1: for WU.S with a negative input of magnitude ≥1, 1 = result 0 with NV; 0 = result 0 without NV.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request pulse; accepted only in IDLE.
- op  in  2  operation: 00 S.W (signed int→float), 01 S.WU (unsigned int→float), 10 W.S (float→signed int), 11 WU.S (float→unsigned int).
- src  in  32  operand; integer or IEEE754 single, per op.
- busy  out  1  high while a conversion is in flight.
- done  out  1  one-cycle pulse; result and flags are valid.
- result  out  32  converted value; held until the next done.
- flag_nv  out  1  invalid-operation flag; valid with done, held with result.
- flag_nx  out  1  inexact flag; valid with done, held with result.

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE.
  - busy, done, result, flag_nv and flag_nx all reset to 0.
  - Reset mid-operation aborts the conversion: no done is issued.
- States: IDLE, NORM, ROUND, DENORM, FINAL.
- Handshake:
  - start with state≠IDLE is ignored.
  - busy is high from the cycle after an accepted start through the last cycle before done; busy=0 whenever done=1.
  - done is registered and lasts exactly 1 cycle. The FSM is back in IDLE in the done cycle, so a start in the done cycle is accepted.
  - op and src are sampled only at acceptance; later changes have no effect.
- Int→float (op 00/01):
  - Magnitude m[31:0] = |src| for S.W, src for S.WU. exp register initialised to 158. sign = src[31] for S.W, else 0.
  - src==0 → result 0x00000000, no flags, done 1 cycle after start.
  - NORM: each cycle, if m[31]=0 then m<<=1 and exp-=1; else go to ROUND. k = leading-zero count of m (0..31).
  - ROUND uses round-to-nearest-even:
    - frac = m[30:8]; guard = m[7]; sticky = |m[6:0].
    - Round up when guard & (sticky | m[8]).
    - A carry out of frac clears frac and sets exp+1.
    - flag_nx = guard | sticky.
  - result = {sign, exp, frac}. done occurs 2+k cycles after the start cycle.
- Float→int (op 10/11):
  - Unpack s, E, F; unbiased e = E−127.
  - Special cases, each done 1 cycle after start:
    - E==0 (zero or denormal, flushed): result 0, no flags.
    - NaN: result 0x7FFFFFFF (W) / 0xFFFFFFFF (WU), NV.
    - ±Inf, or out of range (W: e≥31, except exactly −2^31, i.e. s=1, e=31, F=0, which gives 0x80000000 with no flags; WU: e≥32, or s=1 with e≥0):
      - W saturates to 0x7FFFFFFF / 0x80000000 by sign, NV.
      - WU saturates to 0xFFFFFFFF (positive) or 0 (negative, NV per SAT_NEG_UNSIGNED).
    - e<0 (|x|<1): result 0, NX=1; WU negative also gives 0 with NX only.
  - Otherwise:
    - M = {1,F,8'b0} (bit 31 set); count = 31−e; go to DENORM.
    - DENORM: each cycle, if count≠0 then M>>=1, sticky|=shifted-out bit, count-=1; else go to FINAL.
    - Rounding is toward zero (truncate); flag_nx = sticky.
    - FINAL: result = s ? −M : M (two's complement, W only).
    - done occurs 2+(31−e) cycles after start; max 33.
- Widths: exp is held in 9 bits internally (no wrap); the count is 5 bits.

Test Plan:
- S.W src=0x00000001 → result 0x3F800000, nv=0, nx=0, done exactly 33 cycles after start, busy high for 32 cycles.
- S.W src=0x80000000 → 0xCF000000, no flags, latency 2. S.WU src=0xFFFFFFFF → 0x4F800000 (round carry into exponent), nx=1, latency 2.
- S.W src=0x01000001 → 0x4B800000 (tie to even), nx=1, latency 9. src=0 → 0x00000000, latency 1.
- W.S src=0xC0700000 (−3.75) → 0xFFFFFFFD, nx=1, latency 32. W.S src=0xCF000000 → 0x80000000, no flags.
- W.S src=0x7FC00000 → 0x7FFFFFFF, nv=1, latency 1. WU.S src=0xBF800000 → 0, nv=1. WU.S src=0xBF000000 → 0, nx=1, nv=0. W.S src=0x3F000000 → 0, nx=1.
- Handshake and reset cases:
  - start held during busy → ignored, single done.
  - back-to-back start in the done cycle → accepted.
  - rst_n low mid-DENORM → outputs 0 immediately, no done. The next conversion after release is correct.

Source files
------------

// File: rtl/fcvt_seq_if.sv
// Handshake and data bundle between the FP execute stage and the
// sequential float/integer converter.
`timescale 1ns/1ps

interface fcvt_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        flag_nv;
    logic        flag_nx;

    // Requester side: issues operations, observes status and results.
    modport master (
        output start, op, src,
        input  busy, done, result, flag_nv, flag_nx
    );

    // Converter side.
    modport slave (
        input  start, op, src,
        output busy, done, result, flag_nv, flag_nx
    );
endinterface

// File: rtl/fcvt_seq.sv
// Multi-cycle IEEE754 single <-> 32-bit integer converter.
// op: 00 S.W, 01 S.WU (int->float), 10 W.S, 11 WU.S (float->int).
// Normalisation / denormalisation shift one bit per cycle; special cases
// finish in the cycle after acceptance without leaving IDLE.
`timescale 1ns/1ps

module fcvt_seq #(
    parameter bit SAT_NEG_UNSIGNED = 1'b1
) (
    input logic       clk,
    input logic       rst_n,
    fcvt_seq_if.slave bus
);

    typedef enum logic [2:0] {IDLE, NORM, ROUND, DENORM, FINAL} state_t;

    state_t      state;
    logic [31:0] m;          // int->float magnitude, or float->int mantissa
    logic [8:0]  exp;        // biased exponent, wide enough not to wrap
    logic [4:0]  count;      // remaining right shifts
    logic        sign;
    logic        wu;         // unsigned variant of the accepted op
    logic        sticky;     // bits shifted out during DENORM

    // Operand decode, evaluated on the incoming src.
    logic [31:0]       mag;
    logic              f_sign;
    logic [7:0]        f_exp;
    logic [22:0]       f_frac;
    logic signed [9:0] e_unb;
    logic [4:0]        count_init;
    logic              sp_hit;
    logic [31:0]       sp_res;
    logic              sp_nv;
    logic              sp_nx;

    // Rounding of the normalised magnitude.
    logic        guard;
    logic        rnd_sticky;
    logic        round_up;
    logic [23:0] frac_sum;
    logic [8:0]  exp_rnd;

    // Decode src and classify float operands that finish without shifting.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise untaken branches infer latches.
        mag    = (!bus.op[0] && bus.src[31]) ? -bus.src : bus.src;
        f_sign = bus.src[31];
        f_exp  = bus.src[30:23];
        f_frac = bus.src[22:0];
        e_unb  = $signed({2'b00, f_exp}) - 10'sd127;
        count_init = 5'(10'sd31 - e_unb);
        sp_hit = 1'b1;
        sp_res = 32'h0000_0000;
        sp_nv  = 1'b0;
        sp_nx  = 1'b0;
        if (f_exp == 8'd0) begin
            // zero or flushed denormal: defaults
        end else if (f_exp == 8'hFF && f_frac != 23'd0) begin
            sp_res = bus.op[0] ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
            sp_nv  = 1'b1;
        end else if (bus.op[0] && (e_unb >= 10'sd32 || (f_sign && e_unb >= 10'sd0))) begin
            sp_res = f_sign ? 32'h0000_0000 : 32'hFFFF_FFFF;
            sp_nv  = f_sign ? SAT_NEG_UNSIGNED : 1'b1;
        end else if (!bus.op[0] && e_unb >= 10'sd31 &&
                     !(f_sign && e_unb == 10'sd31 && f_frac == 23'd0)) begin
            sp_res = f_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
            sp_nv  = 1'b1;
        end else if (e_unb < 10'sd0) begin
            sp_nx  = 1'b1;
        end else begin
            sp_hit = 1'b0;
        end
    end

    // Round-to-nearest-even on the normalised magnitude held in m.
    always_comb begin
        guard      = m[7];
        rnd_sticky = |m[6:0];
        round_up   = guard & (rnd_sticky | m[8]);
        frac_sum   = {1'b0, m[30:8]} + 24'(round_up);
        exp_rnd    = exp + 9'(frac_sum[23]);
    end

    // Conversion FSM; all handshake outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            m           <= '0;
            exp         <= '0;
            count       <= '0;
            sign        <= 1'b0;
            wu          <= 1'b0;
            sticky      <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.result  <= '0;
            bus.flag_nv <= 1'b0;
            bus.flag_nx <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register sees pre-edge values regardless of statement order.
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        wu <= bus.op[0];
                        if (!bus.op[1]) begin
                            sign <= !bus.op[0] && bus.src[31];
                            m    <= mag;
                            exp  <= 9'd158;
                            if (mag == 32'd0) begin
                                bus.result  <= '0;
                                bus.flag_nv <= 1'b0;
                                bus.flag_nx <= 1'b0;
                                bus.done    <= 1'b1;
                            end else begin
                                bus.busy <= 1'b1;
                                // Already normalised: the leading one is checked
                                // one step ahead so no idle NORM cycle is spent.
                                state    <= mag[31] ? ROUND : NORM;
                            end
                        end else begin
                            sign   <= f_sign;
                            sticky <= 1'b0;
                            if (sp_hit) begin
                                bus.result  <= sp_res;
                                bus.flag_nv <= sp_nv;
                                bus.flag_nx <= sp_nx;
                                bus.done    <= 1'b1;
                            end else begin
                                m        <= {1'b1, f_frac, 8'b0};
                                count    <= count_init;
                                bus.busy <= 1'b1;
                                state    <= (count_init == 5'd0) ? FINAL : DENORM;
                            end
                        end
                    end
                end
                NORM: begin
                    m   <= m << 1;
                    exp <= exp - 9'd1;
                    if (m[30]) state <= ROUND;
                end
                ROUND: begin
                    // A carry out of the fraction leaves frac_sum[22:0] at zero.
                    bus.result  <= {sign, 31'({exp_rnd, frac_sum[22:0]})};
                    bus.flag_nv <= 1'b0;
                    bus.flag_nx <= guard | rnd_sticky;
                    bus.done    <= 1'b1;
                    bus.busy    <= 1'b0;
                    state       <= IDLE;
                end
                DENORM: begin
                    m      <= m >> 1;
                    sticky <= sticky | m[0];
                    count  <= count - 5'd1;
                    if (count == 5'd1) state <= FINAL;
                end
                FINAL: begin
                    // Truncation toward zero; sign applied in two's complement.
                    bus.result  <= (sign && !wu) ? -m : m;
                    bus.flag_nv <= 1'b0;
                    bus.flag_nx <= sticky;
                    bus.done    <= 1'b1;
                    bus.busy    <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fcvt_seq.sv
// Self-checking bench for fcvt_seq: expected results, flags and latencies are
// queued when a conversion is issued and compared when done pulses.
`timescale 1ns/1ps

module tb_fcvt_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fcvt_seq_if bus ();

    fcvt_seq #(.SAT_NEG_UNSIGNED(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic        nv;
        logic        nx;
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t  sb[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    busy_run = 0;
    int    done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Cycle index, advanced on every active edge.
    always @(posedge clk) cyc++;

    // Output monitor: compares each done against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (bus.busy) busy_run++;
            if (bus.done) begin
                done_cnt++;
                check("busy_in_done", 32'(bus.busy), 32'd0);
                if (sb.size() == 0) begin
                    check("spurious_done", 32'(bus.done), 32'd0);
                end else begin
                    exp_t  e;
                    string t;
                    e = sb.pop_front();
                    t = tag_q.pop_front();
                    check({t, "_res"},  bus.result,         e.res);
                    check({t, "_nv"},   32'(bus.flag_nv),   32'(e.nv));
                    check({t, "_nx"},   32'(bus.flag_nx),   32'(e.nx));
                    check({t, "_lat"},  32'(cyc - e.start_cyc), 32'(e.lat));
                    check({t, "_busy"}, 32'(busy_run),      32'(e.lat - 1));
                end
                busy_run = 0;
            end
        end
    end

    // Issue one conversion; start stays high for 1+hold cycles (extra ones
    // land while busy and must be ignored). Returns at edge+1.
    task automatic drive(input string tag, input logic [1:0] op, input logic [31:0] src,
                         input logic [31:0] res, input logic nv, input logic nx,
                         input int lat, input int hold);
        exp_t e;
        e.res = res; e.nv = nv; e.nx = nx; e.lat = lat; e.start_cyc = cyc;
        sb.push_back(e);
        tag_q.push_back(tag);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src   = src;
        @(posedge clk); #1;
        for (int h = 0; h < hold; h++) begin
            bus.src = $urandom;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.op    = 2'($urandom_range(0, 3));
        bus.src   = $urandom;
    endtask

    // Wait (bounded) until done is visible; returns inside the done cycle.
    task automatic wait_done(input string tag);
        int i = 0;
        while (!bus.done && i < 40) begin
            @(posedge clk); #1;
            i++;
        end
        check({tag, "_done_seen"}, 32'(bus.done), 32'd1);
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] src,
                       input logic [31:0] res, input logic nv, input logic nx, input int lat);
        drive(tag, op, src, res, nv, nx, lat, 0);
        wait_done(tag);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},   32'(bus.busy),    32'd0);
        check({tag, "_done"},   32'(bus.done),    32'd0);
        check({tag, "_result"}, bus.result,       32'd0);
        check({tag, "_nv"},     32'(bus.flag_nv), 32'd0);
        check({tag, "_nx"},     32'(bus.flag_nx), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int d0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.src   = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // start held while busy: only one conversion, one done
        d0 = done_cnt;
        drive("sw_one_hold", 2'b00, 32'h0000_0001, 32'h3F80_0000, 1'b0, 1'b0, 33, 4);
        wait_done("sw_one_hold");
        repeat (3) @(posedge clk);
        #1;
        check("hold_single_done", 32'(done_cnt - d0), 32'd1);

        // Each run returns in the done cycle, so the next start is back-to-back.
        run("sw_min",      2'b00, 32'h8000_0000, 32'hCF00_0000, 1'b0, 1'b0, 2);
        run("swu_allones", 2'b01, 32'hFFFF_FFFF, 32'h4F80_0000, 1'b0, 1'b1, 2);
        run("sw_tie_even", 2'b00, 32'h0100_0001, 32'h4B80_0000, 1'b0, 1'b1, 9);
        run("sw_zero",     2'b00, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1);
        run("sw_neg_one",  2'b00, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 1'b0, 33);
        run("swu_msb",     2'b01, 32'h8000_0000, 32'h4F00_0000, 1'b0, 1'b0, 2);
        run("ws_m3p75",    2'b10, 32'hC070_0000, 32'hFFFF_FFFD, 1'b0, 1'b1, 32);
        run("ws_min_int",  2'b10, 32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 2);
        run("ws_nan",      2'b10, 32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
        run("wus_neg_one", 2'b11, 32'hBF80_0000, 32'h0000_0000, 1'b1, 1'b0, 1);
        run("wus_neg_half",2'b11, 32'hBF00_0000, 32'h0000_0000, 1'b0, 1'b1, 1);
        run("ws_half",     2'b10, 32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 1);
        run("ws_neg_inf",  2'b10, 32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 1);
        run("ws_2p31",     2'b10, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
        run("wus_2p32",    2'b11, 32'h4F80_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1);
        run("wus_max",     2'b11, 32'h4F7F_FFFF, 32'hFFFF_FF00, 1'b0, 1'b0, 2);
        run("ws_one",      2'b10, 32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 33);
        run("ws_2p5",      2'b10, 32'h4020_0000, 32'h0000_0002, 1'b0, 1'b1, 32);
        run("ws_denorm",   2'b10, 32'h0040_0000, 32'h0000_0000, 1'b0, 1'b0, 1);
        run("wus_nan",     2'b11, 32'h7FC0_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1);

        // Reset mid-DENORM aborts: outputs clear at once and no done follows.
        drive("ws_aborted", 2'b10, 32'hC070_0000, 32'hFFFF_FFFD, 1'b0, 1'b1, 32, 0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        sb.delete();
        tag_q.delete();
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("no_done_after_abort", 32'(done_cnt - d0), 32'd0);

        run("ws_after_rst", 2'b10, 32'hC070_0000, 32'hFFFF_FFFD, 1'b0, 1'b1, 32);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
